// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Radix-2 shift-add multiply and restoring divide over a shared 2*WIDTH accumulator.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_r, state_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r, acc_next_s;
  logic [WIDTH-1:0]     opnd_r;
  logic                 is_div_r, bzero_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 done_r, div_zero_r;

  logic                 req_s, load_s, mthi_s, mtlo_s, step_s, fin_s, commit_s;
  logic                 signed_s, sa_s, sb_s;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s;
  logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s, res_hi_s, res_lo_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush wins over start and aborts CALC/FIX
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!flush && start && !op[2]) state_next_s = S_CALC;
        else                           state_next_s = S_IDLE;
      end
      S_CALC: begin
        if (flush)                        state_next_s = S_IDLE;
        else if (cnt_r == {CNT_W{1'b0}})  state_next_s = S_FIX;
        else                              state_next_s = S_CALC;
      end
      S_FIX:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Control decode from the current state
  always_comb begin
    req_s    = (state_r == S_IDLE) && start && !flush;
    load_s   = req_s && !op[2];
    mthi_s   = req_s && (op == OP_MTHI);
    mtlo_s   = req_s && (op == OP_MTLO);
    step_s   = (state_r == S_CALC) && !flush;
    fin_s    = (state_r == S_FIX) && !flush;
    commit_s = fin_s && !(is_div_r && bzero_r);
  end

  // Operand magnitudes and sign flags at issue
  always_comb begin
    signed_s = ~op[0];
    sa_s     = signed_s & a[WIDTH-1];
    sb_s     = signed_s & b[WIDTH-1];
    mag_a_s  = sa_s ? neg_w(a) : a;
    mag_b_s  = sb_s ? neg_w(b) : b;
  end

  // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (is_div_r) begin
      if (div_diff_s[WIDTH]) acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      else                   acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    prod_s = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
    quo_s  = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s  = neg_r_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    if (is_div_r) begin
      res_hi_s = rem_s;
      res_lo_s = quo_s;
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      bzero_r    <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      if (load_s) begin
        cnt_r    <= CNT_W'(WIDTH - 1);
        is_div_r <= op[1];
        bzero_r  <= (b == {WIDTH{1'b0}});
        neg_q_r  <= sa_s ^ sb_s;
        neg_r_r  <= sa_s;
        opnd_r   <= op[1] ? mag_b_s : mag_a_s;
        acc_r    <= {{WIDTH{1'b0}}, (op[1] ? mag_a_s : mag_b_s)};
      end else if (step_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
        acc_r <= acc_next_s;
      end else begin
        cnt_r <= cnt_r;
        acc_r <= acc_r;
      end
      if (commit_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else if (mthi_s) begin
        hi_r <= a;
      end else if (mtlo_s) begin
        lo_r <= a;
      end else begin
        hi_r <= hi_r;
      end
      done_r     <= fin_s;
      div_zero_r <= fin_s && is_div_r && bzero_r;
    end
  end

  assign busy     = (state_r != S_IDLE);
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        d8_start = 1'b0;
  logic [2:0]  d8_op = 3'd0;
  logic [7:0]  d8_a = 8'd0, d8_b = 8'd0;
  logic        d8_busy, d8_done, d8_div_zero;
  logic [7:0]  d8_hi, d8_lo;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;
  logic        exp_dz = 1'b0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(d8_start), .op(d8_op), .a(d8_a), .b(d8_b), .flush(1'b0),
    .busy(d8_busy), .done(d8_done), .div_zero(d8_div_zero), .hi(d8_hi), .lo(d8_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference behaviour: what HI/LO hold after the operation commits
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    exp_dz = 1'b0;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, x} * {32'd0, y};
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      3'd2: begin
        if (y == 32'd0) exp_dz = 1'b1;
        else begin
          sx = longint'($signed(x)); sy = longint'($signed(y));
          q = sx / sy; r = sx % sy;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end
      end
      3'd3: begin
        if (y == 32'd0) exp_dz = 1'b1;
        else begin
          exp_lo = x / y; exp_hi = x % y;
        end
      end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
  endtask

  task automatic wait_done(input string tag, input int want_lat);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, want_lat);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (o[2]) begin
      check("mt_busy", busy, 1'b0);
      check("mt_done", done, 1'b0);
    end else begin
      check("op_busy", busy, 1'b1);
      wait_done("op", 33);
      check("op_div_zero", div_zero, exp_dz);
    end
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
    if (!o[2]) begin
      @(negedge clk);
      check("done_pulse", done, 1'b0);
      check("busy_after", busy, 1'b0);
      check("dz_pulse", div_zero, 1'b0);
    end
  endtask

  initial begin
    int dones;
    logic [31:0] x, y;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(3'd0, 32'hFFFFFFFD, 32'h00000005);
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002);
    run_op(3'd3, 32'h00000007, 32'h00000002);
    run_op(3'd4, 32'h12345678, 32'h0);
    run_op(3'd3, 32'h00000005, 32'h00000000);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd2, 32'h00000009, 32'h00000000);

    // Flush in IDLE beats start
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hCAFEF00D; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_hi", hi, exp_hi);

    // Starts while busy are dropped
    model(3'd1, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hDEAD;
    @(negedge clk);
    op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 33 - 5);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'hC);
    @(negedge clk);
    check("ign_idle", busy, 1'b0);

    // Flush mid-CALC: no done, HI/LO untouched
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush_no_done", dones, 0);
    check("flush_hi", hi, exp_hi);
    check("flush_lo", lo, exp_lo);

    // Reset mid-CALC clears everything at once
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_done", done, 1'b0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized ops with biased operand corners
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: x = 32'h80000000;
        3: y = $urandom_range(1, 9);
        default: ;
      endcase
      run_op(3'($urandom_range(0, 7)), x, y);
    end

    // Narrow instance: FF*FF unsigned in 9 edges
    @(negedge clk);
    d8_start = 1'b1; d8_op = 3'd1; d8_a = 8'hFF; d8_b = 8'hFF;
    @(negedge clk);
    d8_start = 1'b0;
    begin
      int n = 0;
      while (!d8_done && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("w8_latency", n, 9);
    end
    check("w8_hi", d8_hi, 8'hFE);
    check("w8_lo", d8_lo, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
